uart_autobaud: RTL and testbench



---
 rtl/uart_autobaud.sv | 164 ++++++++++++++++
 tb/tb_uart_autobaud.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the host UART bit period from a 0x55 sync byte and
// supplies the receiver divisor, with lock/error status and a manual override.
//
//   state      | meaning
//   WAIT_START | counters cleared, waiting for the start-bit falling edge
//   MEASURE    | timing the eight bit intervals of the sync byte
//   SETTLE     | divisor loaded, waiting for 2*cpb idle-high cycles
//   LOCKED     | divisor valid and line idle, held until rearm
//   ERROR      | measurement failed, held until rearm
module uart_autobaud #(
  parameter int               CNT_W       = 16,
  parameter int               MIN_BIT     = 4,
  parameter logic [CNT_W-1:0] DEFAULT_CPB = 16'd87
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic             rearm_i,
  input  logic             override_en_i,
  input  logic [CNT_W-1:0] override_cpb_i,
  output logic [CNT_W-1:0] clks_per_bit_o,
  output logic             locked_o,
  output logic             error_o
);

  typedef enum logic [2:0] {
    WAIT_START = 3'd0,
    MEASURE    = 3'd1,
    SETTLE     = 3'd2,
    LOCKED     = 3'd3,
    ERROR      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_BIT);

  state_t state, next_state;

  logic rx_s1, rx_s2, rx_d;
  logic edge_det, fall;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ref_int;
  logic [3:0]       idx;
  logic [CNT_W+2:0] total;
  logic [CNT_W+2:0] total_sum;
  logic [CNT_W+2:0] rounded;
  logic [CNT_W-1:0] cpb_new;
  logic [CNT_W-1:0] diff;
  logic [CNT_W:0]   idle;
  logic [CNT_W-1:0] cpb_q;

  logic too_short, off_ref, timeout;
  logic meas_err, meas_done, idle_done;
  logic locked_nxt, error_nxt;

  // Two-flop synchronizer plus edge-detect register, all idle-high
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign edge_det = rx_s2 ^ rx_d;
  assign fall     = rx_d & ~rx_s2;

  // cnt holds the cycles elapsed since the last edge, so on an edge it is the interval
  always_comb begin
    diff      = (cnt > ref_int) ? (cnt - ref_int) : (ref_int - cnt);
    too_short = (cnt < MIN_V);
    off_ref   = (idx != 4'd0) && (diff > (ref_int >> 2));
    timeout   = (cnt == CNT_MAX);
    meas_err  = timeout || (edge_det && (too_short || off_ref));
    meas_done = edge_det && !meas_err && (idx == 4'd7);
    total_sum = total + {3'b000, cnt};
    rounded   = total_sum + (CNT_W+3)'(4);
    cpb_new   = CNT_W'(rounded >> 3);
    idle_done = rx_s2 && ((idle + (CNT_W+1)'(1)) >= {cpb_q, 1'b0});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= WAIT_START;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (rearm_i) begin
      next_state = WAIT_START;
    end else begin
      case (state)
        WAIT_START: if (fall) next_state = MEASURE;
        MEASURE: begin
          if (meas_err)       next_state = ERROR;
          else if (meas_done) next_state = SETTLE;
        end
        SETTLE:  if (idle_done) next_state = LOCKED;
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    locked_nxt = (next_state == LOCKED);
    error_nxt  = (next_state == ERROR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_o <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      locked_o <= locked_nxt;
      error_o  <= error_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      ref_int <= '0;
      idx     <= 4'd0;
      total   <= '0;
      idle    <= '0;
    end else begin
      case (state)
        WAIT_START: begin
          cnt   <= fall ? CNT_W'(1) : '0;
          idx   <= 4'd0;
          total <= '0;
          idle  <= '0;
        end
        MEASURE: begin
          idle <= '0;
          if (edge_det) begin
            cnt   <= CNT_W'(1);
            idx   <= idx + 4'd1;
            total <= total_sum;
            if (idx == 4'd0) ref_int <= cnt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SETTLE: idle <= rx_s2 ? (idle + (CNT_W+1)'(1)) : '0;
        default: idle <= '0;
      endcase
    end
  end

  // Divisor survives rearm and errors; only a clean eighth interval reloads it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                          cpb_q <= DEFAULT_CPB;
    else if ((state == MEASURE) && meas_done && !rearm_i) cpb_q <= cpb_new;
  end

  assign clks_per_bit_o = override_en_i ? override_cpb_i : cpb_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed and randomized sync-byte frames for uart_autobaud, checked against an
// interval-list reference model.
module tb_uart_autobaud;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        rx_i;
  logic        rearm_i;
  logic        override_en_i;
  logic [15:0] override_cpb_i;
  logic [15:0] clks_per_bit_o;
  logic        locked_o;
  logic        error_o;

  int errors = 0;
  int checks = 0;
  int seg[16];
  int nseg;
  int exp_cpb;

  uart_autobaud dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .rx_i           (rx_i),
    .rearm_i        (rearm_i),
    .override_en_i  (override_en_i),
    .override_cpb_i (override_cpb_i),
    .clks_per_bit_o (clks_per_bit_o),
    .locked_o       (locked_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Line segments alternate low/high starting with the start bit; each edge ends an interval
  function automatic void model(output bit err, output int cpb);
    int ref_v, sum, iv, d;
    err = 1'b0;
    sum = 0;
    cpb = 0;
    ref_v = seg[0];
    for (int i = 0; i < 8; i++) begin
      iv = (i < nseg) ? seg[i] : 65535;
      d  = (iv > ref_v) ? iv - ref_v : ref_v - iv;
      if (iv < 4 || iv >= 65535 || d > ref_v / 4) begin
        err = 1'b1;
        break;
      end
      sum += iv;
    end
    if (!err) cpb = (sum + 4) / 8;
  endfunction

  task automatic build_frame(input logic [7:0] b, input int len);
    logic [8:0] lv;
    lv = {b, 1'b0};
    nseg = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0 || lv[i] != lv[i-1]) begin
        seg[nseg] = len;
        nseg++;
      end else begin
        seg[nseg-1] += len;
      end
    end
  endtask

  task automatic play(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      rx_i = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (seg[i]) @(negedge clk);
    end
  endtask

  task automatic rearm();
    @(negedge clk);
    rearm_i = 1'b1;
    @(negedge clk);
    rearm_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input string tag);
    bit err;
    int cpb;
    int k;
    model(err, cpb);
    @(negedge clk);
    play(0, nseg - 1);
    rx_i = 1'b1;
    if (!err) begin
      k = 0;
      while (locked_o !== 1'b1 && k < 2 * cpb + 40) begin
        @(posedge clk);
        #1;
        k++;
      end
      exp_cpb = cpb;
      check({tag, " locked"}, {31'd0, locked_o}, 1);
      check({tag, " cpb"}, {16'd0, clks_per_bit_o}, exp_cpb);
      check({tag, " error"}, {31'd0, error_o}, 0);
    end else begin
      repeat (10) @(posedge clk);
      #1;
      check({tag, " error"}, {31'd0, error_o}, 1);
      check({tag, " locked"}, {31'd0, locked_o}, 0);
      check({tag, " cpb kept"}, {16'd0, clks_per_bit_o}, exp_cpb);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    rx_i = 1'b1;
    rearm_i = 1'b0;
    override_en_i = 1'b0;
    override_cpb_i = 16'd0;
    exp_cpb = 87;
    repeat (3) @(negedge clk);
    #1;
    check("reset cpb", {16'd0, clks_per_bit_o}, 87);
    check("reset locked", {31'd0, locked_o}, 0);
    check("reset error", {31'd0, error_o}, 0);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);

    // 2-cycle glitch
    nseg = 1;
    seg[0] = 2;
    run_frame("glitch");

    // Nominal 16 clk/bit with exact divisor and lock latency
    rearm();
    check("rearm clears error", {31'd0, error_o}, 0);
    build_frame(8'h55, 16);
    @(negedge clk);
    play(0, 7);
    rx_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("cpb before 8th edge", {16'd0, clks_per_bit_o}, 87);
    @(posedge clk);
    #1;
    check("cpb after 8th edge", {16'd0, clks_per_bit_o}, 16);
    repeat (seg[8] - 3) @(negedge clk);
    rx_i = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    check("locked before 32 idle", {31'd0, locked_o}, 0);
    @(posedge clk);
    #1;
    check("locked after 32 idle", {31'd0, locked_o}, 1);
    check("nominal error", {31'd0, error_o}, 0);
    exp_cpb = 16;

    // Override mux is combinational
    @(negedge clk);
    override_cpb_i = 16'd100;
    override_en_i = 1'b1;
    #1;
    check("override on", {16'd0, clks_per_bit_o}, 100);
    override_en_i = 1'b0;
    #1;
    check("override off", {16'd0, clks_per_bit_o}, exp_cpb);

    rearm();
    check("rearm locked", {31'd0, locked_o}, 0);
    check("rearm cpb kept", {16'd0, clks_per_bit_o}, 16);
    build_frame(8'h55, 24);
    run_frame("baud24");

    rearm();
    build_frame(8'h57, 16);
    run_frame("wrong sync");

    rearm();
    build_frame(8'h55, 434);
    run_frame("baud434");

    rearm();
    nseg = 9;
    for (int i = 0; i < 8; i++) seg[i] = (i % 2 == 0) ? 15 : 17;
    seg[8] = 16;
    run_frame("jitter");

    for (int r = 0; r < 4; r++) begin
      int base, j;
      base = int'($urandom_range(8, 40));
      j = base / 8;
      nseg = 9;
      for (int i = 0; i < 9; i++) seg[i] = base - j + int'($urandom_range(0, 2 * j));
      rearm();
      run_frame("random");
    end

    // Reset in the middle of a measurement
    rearm();
    build_frame(8'h55, 16);
    @(negedge clk);
    play(0, 3);
    rx_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    exp_cpb = 87;
    check("midreset cpb", {16'd0, clks_per_bit_o}, 87);
    check("midreset locked", {31'd0, locked_o}, 0);
    check("midreset error", {31'd0, error_o}, 0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    build_frame(8'h55, 16);
    run_frame("post reset");

    // Line held low after the start edge
    rearm();
    rx_i = 1'b0;
    repeat (65500) @(posedge clk);
    #1;
    check("timeout early", {31'd0, error_o}, 0);
    repeat (45) @(posedge clk);
    #1;
    check("timeout error", {31'd0, error_o}, 1);
    check("timeout cpb kept", {16'd0, clks_per_bit_o}, exp_cpb);
    check("timeout locked", {31'd0, locked_o}, 0);
    rx_i = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
